fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
Downstream stage of the synchronous FIFO. It drains the FIFO's registered read port and re-presents the data as a valid/ready stream with full throughput and back-pressure. It also frames the stream into fixed-length packets by asserting o_last on every PKT_LEN-th beat. It shares the FIFO's single clock domain.

Parameters:
DATA_WIDTH, 64, stream and FIFO data width; must match the FIFO.
PKT_LEN, 16, beats per packet; must be >= 1; o_last marks beat PKT_LEN-1.
CNT_W, (PKT_LEN>1 ? $clog2(PKT_LEN) : 1), beat counter width; derived, not to be overridden.

Ports:
i_wr_clk  in  1  clock; same clock as the FIFO.
i_rstn  in  1  asynchronous, active-low reset.
i_clr  in  1  synchronous clear: drops buffered and in-flight beats and restarts packet framing.
o_fifo_rd_en  out  1  read request to the FIFO.
i_fifo_empty  in  1  FIFO empty flag.
i_fifo_rd_data  in  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read.
o_valid  out  1  stream beat valid.
i_ready  in  1  downstream ready.
o_data  out  DATA_WIDTH  stream beat data.
o_last  out  1  last beat of packet; qualified by o_valid.
o_occupancy  out  2  beats held in the internal buffer (0..2).

Behaviour:
- Reset (i_rstn low, async): o_valid=0, o_data=0, o_last=0, o_occupancy=0, in-flight flag=0, beat counter=0. o_fifo_rd_en=0 while in reset.
- FIFO contract:
  - A read is accepted when o_fifo_rd_en && !i_fifo_empty.
  - i_fifo_rd_data is captured exactly one cycle later, using a registered in-flight flag (inflight <= accepted read).
  - Accepted reads never reach the FIFO while it is empty, because o_fifo_rd_en already includes !i_fifo_empty.
- Pop: pop = o_valid && i_ready.
- Read request: o_fifo_rd_en = !i_fifo_empty && !i_clr && (occ + inflight - pop) <= 1.
  - Combinational path from i_ready is intentional; it gives one beat per cycle in steady state.
  - The buffer can never overflow beyond 2 entries.
- Buffer: 2-entry, in-order (head/skid).
  - o_data always equals the head entry; o_valid = (occ != 0).
  - Push when inflight=1 and i_clr=0.
  - Push and pop in the same cycle leave occ unchanged; the head advances and the new beat takes the vacated slot, order preserved.
  - Push into empty buffer: beat appears on o_data the next cycle, so FIFO-accept to o_valid latency is 2 cycles.
- Stall: while o_valid && !i_ready, o_data and o_last hold stable; o_valid never drops without a pop.
- Framing:
  - Beat counter cnt increments on pop and wraps from PKT_LEN-1 to 0.
  - o_last = o_valid && (cnt == PKT_LEN-1).
  - PKT_LEN=1 gives o_last=o_valid on every beat.
- i_clr (synchronous, highest priority):
  - Next cycle: occ=0, cnt=0.
  - A beat arriving because of a read accepted before the clear (inflight=1 during the i_clr cycle, or on the cycle after) is discarded.
  - No read is issued while i_clr=1.
  - A pop coincident with i_clr still counts as transferred downstream; the counter is nevertheless cleared.
- FIFO empty mid-packet: o_valid drops once the buffer drains; framing resumes from the same cnt, with no packet truncation.
- Reset mid-operation: all state returns to reset values immediately; beats in flight are lost.

Decomposition:
- Shared package fifo_pkg: default DATA_WIDTH, PKT_LEN, and a counter-width function (clog2 with minimum 1).
- One sub-module: stream_skid_buf, the 2-entry in-order buffer with push/pop/occ, parameterised on DATA_WIDTH.
- The top level holds the read-request logic, the in-flight flag, the framing counter and the clear handling.

Test Plan:
1. Reset release with FIFO holding 0x11,0x22,0x33 and i_ready=1 -> o_fifo_rd_en rises the first cycle after reset; o_valid first high 2 cycles after the first accepted read; beats 0x11,0x22,0x33 appear on consecutive cycles.
2. Stream 40 beats, PKT_LEN=16, i_ready=1 -> one beat per cycle after fill; o_last high on beats 15 and 31 only; cnt=8 at the end.
3. i_ready held low for 5 cycles with FIFO non-empty -> occ saturates at 2; o_fifo_rd_en=0; o_data stable; no beat lost or duplicated on release.
4. Random i_ready (50%) over 1000 beats of an incrementing pattern -> output sequence exactly 0..999; o_last on every beat index ≡15 mod 16.
5. Assert i_clr for 1 cycle with occ=2 and a read in flight -> o_valid=0 next cycle; in-flight beat dropped; next output is the following FIFO word; o_last on its 16th beat.
6. FIFO runs empty after beat 7 of a packet, refills 10 cycles later -> o_valid low in the gap; o_last on the 8th beat after resume.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream stage.
package fifo_pkg;

  localparam int unsigned DefDataWidth = 64;
  localparam int unsigned DefPktLen    = 16;

  // Occupancy of the 2-entry output buffer (0..2).
  typedef logic [1:0] occ_t;

  localparam occ_t OccEmpty = 2'd0;
  localparam occ_t OccOne   = 2'd1;
  localparam occ_t OccFull  = 2'd2;

  // Beat counter width: clog2 with a floor of one bit so PKT_LEN=1 still works.
  function automatic int unsigned cnt_width(input int unsigned pkt_len);
    return (pkt_len > 1) ? $clog2(pkt_len) : 1;
  endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order buffer (head + skid) feeding a valid/ready stream.
// The head entry is always the presented beat; the skid entry only fills while the
// head is stalled.
module stream_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  input  logic                  i_push,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_pop,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output occ_t                  o_occ
);

  logic [DATA_WIDTH-1:0] head, head_next;
  logic [DATA_WIDTH-1:0] skid, skid_next;
  occ_t                  occ, occ_next;

  // Next-state: clear wins; push/pop keep order by shifting skid into head.
  always_comb begin
    head_next = head;
    skid_next = skid;
    occ_next  = occ;
    if (i_clr) begin
      occ_next = OccEmpty;
    end else begin
      case ({i_push, i_pop})
        2'b10: begin
          occ_next = occ_t'(occ + 2'd1);
          if (occ == OccEmpty) begin
            head_next = i_data;
          end else begin
            skid_next = i_data;
          end
        end
        2'b01: begin
          occ_next  = occ_t'(occ - 2'd1);
          head_next = skid;
        end
        2'b11: begin
          // Occupancy unchanged; new beat takes the slot the head vacates.
          if (occ == OccFull) begin
            head_next = skid;
            skid_next = i_data;
          end else begin
            head_next = i_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      head <= '0;
      skid <= '0;
      occ  <= OccEmpty;
    end else begin
      head <= head_next;
      skid <= skid_next;
      occ  <= occ_next;
    end
  end

  // Outputs are direct register views.
  always_comb begin
    o_data  = head;
    o_occ   = occ;
    o_valid = (occ != OccEmpty);
  end

endmodule

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous FIFO's registered read port into a valid/ready stream
// with full throughput, and frames it into PKT_LEN-beat packets via o_last.
module fifo_stream_reader
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned PKT_LEN    = DefPktLen,
  parameter int unsigned CNT_W      = cnt_width(PKT_LEN)
) (
  input  logic                  i_wr_clk,
  input  logic                  i_rstn,
  input  logic                  i_clr,
  output logic                  o_fifo_rd_en,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_rd_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic [1:0]            o_occupancy
);

  localparam logic [CNT_W-1:0] CntMax = CNT_W'(PKT_LEN - 1);

  logic             pop;
  logic             push;
  logic             inflight;
  logic [2:0]       occ_proj;
  logic [CNT_W-1:0] cnt, cnt_next;
  occ_t             occ;

  // Read request: only issue when the beat is guaranteed a buffer slot. The
  // pop term makes this combinational on i_ready, which is what sustains one
  // beat per cycle.
  always_comb begin
    pop          = o_valid && i_ready;
    push         = inflight && !i_clr;
    occ_proj     = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    o_fifo_rd_en = i_rstn && !i_fifo_empty && !i_clr && (occ_proj <= 3'd1);
  end

  // In-flight flag: marks that i_fifo_rd_data carries a beat this cycle.
  always_ff @(posedge i_wr_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      inflight <= 1'b0;
    end else begin
      inflight <= o_fifo_rd_en;
    end
  end

  // Beat counter next-state: clear restarts framing even on a coincident pop.
  always_comb begin
    cnt_next = cnt;
    if (i_clr) begin
      cnt_next = '0;
    end else if (pop) begin
      cnt_next = (cnt == CntMax) ? '0 : cnt + CNT_W'(1);
    end
  end

  // Beat counter register.
  always_ff @(posedge i_wr_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

  stream_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_skid_buf (
    .i_clk   (i_wr_clk),
    .i_rstn  (i_rstn),
    .i_clr   (i_clr),
    .i_push  (push),
    .i_data  (i_fifo_rd_data),
    .i_pop   (pop),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_occ   (occ)
  );

  // Framing and occupancy outputs.
  always_comb begin
    o_last      = o_valid && (cnt == CntMax);
    o_occupancy = occ;
  end

endmodule
